diff_codec: RTL and testbench

- Parametrised M-ary differential encoder/decoder for the comms datapath; successor to the single-bit XOR differential encoder.
- Symbols are SYM_W bits wide, combined modulo 2^SYM_W, which supports DBPSK/DQPSK/D8PSK-style phase-difference coding.
- Holds independent reference state for NUM_CH time-interleaved channels.
- Uses valid/ready handshakes on input and output, with one registered output stage.

---
 rtl/diff_codec.sv | 103 ++++++++++
 tb/tb_diff_codec.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_codec.sv
// diff_codec: M-ary differential encoder/decoder, symbols combined modulo 2^SYM_W, one reference per interleaved channel.
// Latency: one cycle from input accept to out_valid; sustains one symbol per cycle while out_ready is high.
// Backpressure: in_ready drops while a held output is not taken (out_valid && !out_ready), during clear and during reset.
module diff_codec #(
  parameter int unsigned       SYM_W    = 2,
  parameter int unsigned       NUM_CH   = 4,
  parameter logic [SYM_W-1:0]  INIT_VAL = '0,
  localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic [CH_W-1:0]  out_ch
);

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [CH_W-1:0]  ch;
  } out_t;

  logic [SYM_W-1:0] ref_q [NUM_CH];
  logic [SYM_W-1:0] ref_d [NUM_CH];
  out_t             out_q;
  out_t             out_d;
  logic             out_valid_q;
  logic             out_valid_d;

  logic [CH_W-1:0]  ch_idx;
  logic             accept;
  logic [SYM_W-1:0] ref_sel;
  logic [SYM_W-1:0] coded;

  // A single channel has no index to decode, so whatever arrives on in_ch is ignored.
  assign ch_idx = (NUM_CH == 1) ? '0 : in_ch;

  // Ready depends only on output occupancy, clear and reset, never on in_valid.
  assign in_ready = !reset && !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Select the channel reference; an index past NUM_CH matches nothing and falls back to INIT_VAL.
  always_comb begin
    ref_sel = INIT_VAL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == i[CH_W-1:0]) begin
        ref_sel = ref_q[i];
      end
    end
  end

  // Modulo-2^SYM_W arithmetic falls out of the SYM_W-bit result width.
  assign coded = mode ? (in_sym - ref_sel) : (in_sym + ref_sel);

  // Next state: clear reloads references, an accept loads the output stage and updates its channel.
  always_comb begin
    ref_d       = ref_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ref_d[i] = INIT_VAL;
      end
    end
    if (accept) begin
      out_d.sym   = coded;
      out_d.ch    = ch_idx;
      out_valid_d = 1'b1;
      // Encoder tracks its own output, decoder tracks the received symbol.
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == i[CH_W-1:0]) begin
          ref_d[i] = mode ? in_sym : coded;
        end
      end
    end
  end

  // State registers; reset drops any in-flight output and restores every reference.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ref_q[i] <= INIT_VAL;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ref_q       <= ref_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_q.sym;
  assign out_ch    = out_q.ch;

endmodule

// File: tb/tb_diff_codec.sv
// Bench for diff_codec: directed sequences plus random traffic on three configurations.
// Expected symbols come from a modular-arithmetic reference model and are queued at accept time.
// Monitors compare on the falling edge whenever an output is presented.
module tb_diff_codec;

  localparam int A_W = 2;
  localparam int O_W = 3;
  localparam int O_N = 3;
  localparam int O_INIT = 5;

  logic clock;
  logic reset;
  logic clear;

  logic       a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_in_sym, a_out_sym, a_in_ch, a_out_ch;

  logic       o_in_valid, o_in_ready, oe_valid, od_in_ready, od_valid, od_ready;
  logic [2:0] o_in_sym, oe_sym, od_sym;
  logic [1:0] o_in_ch, oe_ch, od_ch;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic b_in_sym, b_out_sym, b_in_ch, b_out_ch;

  diff_codec #(.SYM_W(A_W), .NUM_CH(4), .INIT_VAL(2'd0)) u_a (
    .clock(clock), .reset(reset), .mode(a_mode), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sym(a_in_sym), .in_ch(a_in_ch),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sym(a_out_sym), .out_ch(a_out_ch));

  diff_codec #(.SYM_W(O_W), .NUM_CH(O_N), .INIT_VAL(3'd5)) u_oenc (
    .clock(clock), .reset(reset), .mode(1'b0), .clear(clear),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_sym(o_in_sym), .in_ch(o_in_ch),
    .out_valid(oe_valid), .out_ready(od_in_ready), .out_sym(oe_sym), .out_ch(oe_ch));

  diff_codec #(.SYM_W(O_W), .NUM_CH(O_N), .INIT_VAL(3'd5)) u_odec (
    .clock(clock), .reset(reset), .mode(1'b1), .clear(clear),
    .in_valid(oe_valid), .in_ready(od_in_ready), .in_sym(oe_sym), .in_ch(oe_ch),
    .out_valid(od_valid), .out_ready(od_ready), .out_sym(od_sym), .out_ch(od_ch));

  diff_codec #(.SYM_W(1), .NUM_CH(1), .INIT_VAL(1'b0)) u_b (
    .clock(clock), .reset(reset), .mode(1'b0), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sym(b_in_sym), .in_ch(b_in_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sym(b_out_sym), .out_ch(b_out_ch));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { int sym; int ch; } exp_t;
  exp_t q_a[$];
  exp_t q_oe[$];
  exp_t q_od[$];
  exp_t q_b[$];

  int ra[4];
  int ro[O_N];
  int rb;
  int n_chk = 0;
  int n_pass = 0;
  bit rand_a = 0;
  bit rand_o = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  function automatic int modw(input int v, input int w);
    return ((v % (1 << w)) + (1 << w)) % (1 << w);
  endfunction

  task automatic model_reset();
    foreach (ra[i]) ra[i] = 0;
    foreach (ro[i]) ro[i] = O_INIT;
    rb = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    model_reset();
    #1 clear = 1'b0;
  endtask

  // Offer one symbol to the main instance; the model records it when the handshake will complete.
  task automatic send_a(input logic m, input int ch, input int sym);
    exp_t e;
    int r;
    bit done = 0;
    a_mode = m; a_in_ch = ch[1:0]; a_in_sym = sym[1:0]; a_in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (a_in_ready) begin
        #1;
        r = ra[ch];
        e.ch = ch;
        if (m) begin e.sym = modw(sym - r, A_W); ra[ch] = sym; end
        else   begin e.sym = modw(sym + r, A_W); ra[ch] = e.sym; end
        q_a.push_back(e);
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) timeout("send_a");
  endtask

  // Loopback encoder input: channel 3 is out of range for a 3-channel block.
  task automatic send_o(input int ch, input int sym);
    exp_t e, d;
    int r;
    bit done = 0;
    o_in_ch = ch[1:0]; o_in_sym = sym[2:0]; o_in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (o_in_ready) begin
        #1;
        r = (ch < O_N) ? ro[ch] : O_INIT;
        e.sym = modw(sym + r, O_W); e.ch = ch;
        if (ch < O_N) ro[ch] = e.sym;
        d.sym = sym; d.ch = ch;
        q_oe.push_back(e);
        q_od.push_back(d);
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) timeout("send_o");
  endtask

  // Single-bit encoder: output is input XOR previous output, channel always 0.
  task automatic send_b(input int bit_in, input int ch);
    exp_t e;
    bit done = 0;
    b_in_sym = bit_in[0]; b_in_ch = ch[0]; b_in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (b_in_ready) begin
        #1;
        e.sym = bit_in ^ rb; e.ch = 0;
        rb = e.sym;
        q_b.push_back(e);
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) timeout("send_b");
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (q_a.size() == 0 && q_oe.size() == 0 && q_od.size() == 0 && q_b.size() == 0) ok = 1;
      else begin @(posedge clock); #1; end
    end
    if (!ok) timeout(name);
  endtask

  // Main instance monitor: valid and ready follow the model, data matches the queue head.
  always @(negedge clock) begin
    chk("a_out_valid", a_out_valid, q_a.size() != 0);
    chk("a_in_ready", a_in_ready, !reset && !clear && (q_a.size() == 0 || a_out_ready));
    if (a_out_valid && q_a.size() != 0) begin
      chk("a_out_sym", a_out_sym, q_a[0].sym);
      chk("a_out_ch", a_out_ch, q_a[0].ch);
      if (a_out_ready) void'(q_a.pop_front());
    end
  end

  // Loopback encoder output monitor.
  always @(negedge clock) begin
    chk("oe_valid", oe_valid, q_oe.size() != 0);
    if (oe_valid && q_oe.size() != 0) begin
      chk("oe_sym", oe_sym, q_oe[0].sym);
      chk("oe_ch", oe_ch, q_oe[0].ch);
      if (od_in_ready) void'(q_oe.pop_front());
    end
  end

  // Loopback decoder must reproduce the original stream.
  always @(negedge clock) begin
    if (od_valid) begin
      if (q_od.size() == 0) chk("od_spurious", od_valid, 0);
      else begin
        chk("od_sym", od_sym, q_od[0].sym);
        chk("od_ch", od_ch, q_od[0].ch);
        if (od_ready) void'(q_od.pop_front());
      end
    end
  end

  // Single-bit instance monitor.
  always @(negedge clock) begin
    chk("b_out_valid", b_out_valid, q_b.size() != 0);
    if (b_out_valid && q_b.size() != 0) begin
      chk("b_out_sym", b_out_sym, q_b[0].sym);
      chk("b_out_ch", b_out_ch, q_b[0].ch);
      if (b_out_ready) void'(q_b.pop_front());
    end
  end

  // Random downstream readiness during the random phases.
  always @(posedge clock) begin
    #1;
    if (rand_a) a_out_ready = ($urandom_range(0, 3) != 0);
    if (rand_o) begin
      od_ready    = ($urandom_range(0, 2) != 0);
      b_out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    int seq_enc[4] = '{1, 1, 2, 3};
    int seq_dec[4] = '{1, 2, 0, 3};
    int il_ch[4]   = '{0, 1, 0, 1};
    int il_sym[4]  = '{3, 1, 3, 1};

    reset = 1'b0; clear = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_sym = '0; a_in_ch = '0; a_out_ready = 1'b1;
    o_in_valid = 1'b0; o_in_sym = '0; o_in_ch = '0; od_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sym = 1'b0; b_in_ch = 1'b0; b_out_ready = 1'b1;
    model_reset();

    #2 reset = 1'b1;
    #10;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sym", a_out_sym, 0);
    chk("rst_out_ch", a_out_ch, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_oe_valid", oe_valid, 0);
    chk("rst_b_valid", b_out_valid, 0);
    @(posedge clock); #3 reset = 1'b0;
    @(posedge clock); #1;

    // Back-to-back encode on channel 0.
    foreach (seq_enc[i]) send_a(1'b0, 0, seq_enc[i]);
    a_in_valid = 1'b0;
    drain("drain_enc");

    // Decode from a fresh reference.
    do_clear();
    foreach (seq_dec[i]) send_a(1'b1, 0, seq_dec[i]);
    a_in_valid = 1'b0;
    drain("drain_dec");

    // Two interleaved channels keep independent references.
    do_clear();
    foreach (il_ch[i]) send_a(1'b0, il_ch[i], il_sym[i]);
    a_in_valid = 1'b0;
    drain("drain_il");

    // Stall the output for several cycles with a second symbol waiting.
    a_out_ready = 1'b0;
    send_a(1'b0, 2, 1);
    fork
      begin
        repeat (4) @(posedge clock);
        #1 a_out_ready = 1'b1;
      end
    join_none
    send_a(1'b0, 2, 3);
    a_in_valid = 1'b0;
    drain("drain_bp");

    // Clear with a symbol offered and an output still pending.
    do_clear();
    send_a(1'b0, 1, 2);
    a_in_valid = 1'b0;
    drain("drain_clr0");
    a_out_ready = 1'b0;
    send_a(1'b0, 3, 1);
    a_mode = 1'b0; a_in_ch = 2'd1; a_in_sym = 2'd1; a_in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    chk("clr_in_ready", a_in_ready, 0);
    @(posedge clock);
    model_reset();
    #1 clear = 1'b0;
    a_out_ready = 1'b1;
    send_a(1'b0, 1, 1);
    a_in_valid = 1'b0;
    drain("drain_clr1");

    // Asynchronous reset while an output is held.
    a_out_ready = 1'b0;
    send_a(1'b0, 0, 1);
    a_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_in_ready", a_in_ready, 0);
    q_a.delete();
    model_reset();
    @(posedge clock); #3 reset = 1'b0;
    @(posedge clock); #1;
    a_out_ready = 1'b1;
    send_a(1'b0, 0, 2);
    a_in_valid = 1'b0;
    drain("drain_rst");

    // Random mixed-mode traffic with occasional clears and idle gaps.
    rand_a = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        a_in_valid = 1'b0;
        do_clear();
      end else begin
        send_a(($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        a_in_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    a_in_valid = 1'b0;
    rand_a = 0;
    @(posedge clock); #1 a_out_ready = 1'b1;
    drain("drain_rand_a");

    // Encoder-to-decoder loopback and single-bit XOR encoder in parallel.
    rand_o = 1;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          send_o($urandom_range(0, 3), $urandom_range(0, 7));
          if ($urandom_range(0, 4) == 0) begin
            o_in_valid = 1'b0;
            @(posedge clock); #1;
          end
        end
        o_in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 150; n++) begin
          send_b($urandom_range(0, 1), $urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) begin
            b_in_valid = 1'b0;
            @(posedge clock); #1;
          end
        end
        b_in_valid = 1'b0;
      end
    join
    rand_o = 0;
    @(posedge clock); #1;
    od_ready = 1'b1;
    b_out_ready = 1'b1;
    drain("drain_rand_o");

    chk("q_a_empty", q_a.size(), 0);
    chk("q_oe_empty", q_oe.size(), 0);
    chk("q_od_empty", q_od.size(), 0);
    chk("q_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
